mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Execute-stage initiator for the 32x32 multiplier datapath: accepts decoded MUL/MLA/UMULL/UMLAL/SMULL/SMLAL,
//  drives the multiplier request (vld/sign/op1/op2/acc), captures the 64-bit result and writes it back through
//  the shared register-file write port (RdLo then RdHi), optionally updating N/Z. Stalls issue (o_busy) while active.
// PARAMETERS
//  MUL_LATENCY  1  cycles from o_mul_vld pulse to first legal result sample (1..15)
//  REG_AW       4  register index width
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  i_start       in   1       multiply instruction valid; accepted only when o_busy=0
//  i_long        in   1       1: 64-bit result (xMULL/xMLAL), 0: 32-bit (MUL/MLA)
//  i_sign        in   1       signed multiply (SMULL/SMLAL); ignored when i_long=0 (treated 0)
//  i_accum       in   1       accumulate (MLA/xMLAL)
//  i_setf        in   1       S bit: update N/Z
//  i_rm, i_rs    in   32      multiplicand / multiplier
//  i_acc_lo      in   32      accumulator low (Rn for MLA, RdLo for xMLAL)
//  i_acc_hi      in   32      accumulator high (RdHi for xMLAL)
//  i_rd_lo       in   REG_AW  destination Rd (short) / RdLo (long)
//  i_rd_hi       in   REG_AW  destination RdHi (long only)
//  i_flush       in   1       pipeline flush: abort current operation
//  o_busy        out  1       state != IDLE
//  o_mul_vld     out  1       one-cycle multiplier request
//  o_mul_sign    out  1       to multiplier
//  o_mul_op1     out  32      = latched rm
//  o_mul_op2     out  32      = latched rs
//  o_mul_acc     out  64      i_accum ? (long ? {hi,lo} : {32'b0,lo}) : 64'b0, latched
//  i_mul_vld     in   1       multiplier result valid
//  i_mul_result  in   64      multiplier result
//  o_wb_en       out  1       write-port request; held until granted
//  i_wb_gnt      in   1       write-port grant (write occurs in cycle o_wb_en & i_wb_gnt)
//  o_wb_addr     out  REG_AW  write index
//  o_wb_data     out  32      write data
//  o_flag_we     out  1       one-cycle N/Z update strobe
//  o_flag_n      out  1       N value
//  o_flag_z      out  1       Z value
//  o_done        out  1       one-cycle pulse, final write granted
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; latched operands/result cleared; wait counter 0.
//  - States: IDLE, ISSUE, WAIT, WB_LO, WB_HI.
//  - IDLE: i_start=1 latches all i_* fields -> ISSUE. o_busy=0 only here.
//  - ISSUE: o_mul_vld=1 for exactly this cycle; counter loaded with MUL_LATENCY -> WAIT.
//  - WAIT: counter decrements to 0; once 0, first cycle with i_mul_vld=1 and o_mul_vld=0 captures i_mul_result -> WB_LO.
//    Waits indefinitely for i_mul_vld; no sampling before counter expires.
//  - WB_LO: o_wb_en=1, addr=rd_lo, data=res[31:0], stable until i_wb_gnt. On grant: long -> WB_HI; else IDLE.
//  - WB_HI: o_wb_en=1, addr=rd_hi, data=res[63:32]; on grant -> IDLE.
//  - Final grant cycle: o_done=1; if setf, o_flag_we=1, N=res[31]/res[63], Z=(res[31:0]==0)/(res==0) (short/long).
//  - Timing, LATENCY=1, gnt always 1: start at T; ISSUE T+1; WAIT/capture T+2; WB_LO T+3; WB_HI T+4 (long); o_busy low T+4 (short) / T+5 (long).
//  - rd_lo==rd_hi (long): both writes issued in order; RdHi last.
//  - i_flush: any state -> IDLE next cycle; no o_wb_en/o_flag_we/o_done that cycle onward; late i_mul_vld ignored.
//    Flush beats grant in same cycle (write suppressed). i_start with o_busy=1 ignored.
//  - Async rst mid-operation: immediate IDLE, outputs 0, no further writes.
// TESTING
//  - MUL rm=7 rs=6 rd_lo=3 setf=1, gnt=1 -> T+3 wb r3=42, flag_we=1 N=0 Z=0, o_done T+3, o_mul_vld only T+1.
//  - SMULL rm=-2 rs=3 lo=r4 hi=r5 setf=1 -> r4=0xFFFFFFFA then r5=0xFFFFFFFF, N=1 Z=0 on r5 write.
//  - UMLAL rm=rs=0xFFFFFFFF acc hi=0 lo=1 -> o_mul_acc=0x1; r_lo=0x00000002, r_hi=0xFFFFFFFE.
//  - MULS rm=0 rs=5, gnt low 3 cycles -> o_wb_en/addr/data stable 4 cycles, single write 0, Z=1 N=0 with grant.
//  - MUL_LATENCY=3, i_mul_vld=1 from T+2 -> capture at T+4, not earlier; i_start during busy ignored.
//  - i_flush in WAIT, then rst asserted in WB_HI -> no writes after flush/reset, IDLE next cycle, next MUL 2*2 -> 4.

Source files
------------

// File: rtl/mul_sequencer.sv
// Execute-stage multiply sequencer: issues one request to the 32x32 multiplier, waits for the result,
// then writes it back through the shared register-file port (RdLo, then RdHi for long forms).
module mul_sequencer #(
  parameter int MUL_LATENCY = 1,
  parameter int REG_AW      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_long,
  input  logic              i_sign,
  input  logic              i_accum,
  input  logic              i_setf,
  input  logic [31:0]       i_rm,
  input  logic [31:0]       i_rs,
  input  logic [31:0]       i_acc_lo,
  input  logic [31:0]       i_acc_hi,
  input  logic [REG_AW-1:0] i_rd_lo,
  input  logic [REG_AW-1:0] i_rd_hi,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_mul_vld,
  output logic              o_mul_sign,
  output logic [31:0]       o_mul_op1,
  output logic [31:0]       o_mul_op2,
  output logic [63:0]       o_mul_acc,
  input  logic              i_mul_vld,
  input  logic [63:0]       i_mul_result,
  output logic              o_wb_en,
  input  logic              i_wb_gnt,
  output logic [REG_AW-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic              o_flag_we,
  output logic              o_flag_n,
  output logic              o_flag_z,
  output logic              o_done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB_LO, WB_HI} state_t;

  // Counter reaches 0 in the first WAIT cycle a result may legally be sampled.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                op_long, op_sign, op_setf;
  logic [31:0]         op_rm, op_rs;
  logic [63:0]         op_acc, res;
  logic [REG_AW-1:0]   op_rd_lo, op_rd_hi;
  logic                final_wr;

  function automatic logic [63:0] acc_form(input logic accum, input logic long_op,
                                           input logic [31:0] lo, input logic [31:0] hi);
    if (!accum)
      return 64'd0;
    return long_op ? {hi, lo} : {32'd0, lo};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0 && i_mul_vld) state_nxt = WB_LO;
      WB_LO:   if (i_wb_gnt) state_nxt = op_long ? WB_HI : IDLE;
      WB_HI:   if (i_wb_gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 4'd0;
      op_long  <= 1'b0;
      op_sign  <= 1'b0;
      op_setf  <= 1'b0;
      op_rm    <= 32'd0;
      op_rs    <= 32'd0;
      op_acc   <= 64'd0;
      op_rd_lo <= '0;
      op_rd_hi <= '0;
      res      <= 64'd0;
    end else begin
      if (state == IDLE && state_nxt == ISSUE) begin
        op_long  <= i_long;
        op_sign  <= i_sign & i_long;
        op_setf  <= i_setf;
        op_rm    <= i_rm;
        op_rs    <= i_rs;
        op_acc   <= acc_form(i_accum, i_long, i_acc_lo, i_acc_hi);
        op_rd_lo <= i_rd_lo;
        op_rd_hi <= i_rd_hi;
      end
      if (state == ISSUE)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (state == WAIT && state_nxt == WB_LO)
        res <= i_mul_result;
    end
  end

  // A flush in the current cycle suppresses every write-side effect immediately.
  always_comb begin
    o_busy     = (state != IDLE);
    o_mul_vld  = (state == ISSUE);
    o_mul_sign = op_sign;
    o_mul_op1  = op_rm;
    o_mul_op2  = op_rs;
    o_mul_acc  = op_acc;
    o_wb_en    = (state == WB_LO || state == WB_HI) && !i_flush;
    o_wb_addr  = (state == WB_HI) ? op_rd_hi : op_rd_lo;
    o_wb_data  = (state == WB_HI) ? res[63:32] : res[31:0];
    final_wr   = o_wb_en && i_wb_gnt && ((state == WB_LO && !op_long) || state == WB_HI);
    o_done     = final_wr;
    o_flag_we  = final_wr && op_setf;
    o_flag_n   = o_flag_we && (op_long ? res[63] : res[31]);
    o_flag_z   = o_flag_we && (op_long ? (res == 64'd0) : (res[31:0] == 32'd0));
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: two instances (latency 1 and 3) share stimulus; a plain-arithmetic
// multiply model supplies results and the expected write-back/flag values.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_long, i_sign, i_accum, i_setf, i_flush;
  logic [31:0] i_rm, i_rs, i_acc_lo, i_acc_hi;
  logic [3:0]  i_rd_lo, i_rd_hi;
  logic        i_mul_vld, i_wb_gnt;
  logic [63:0] i_mul_result;

  logic        a_busy, a_mul_vld, a_mul_sign, a_wb_en, a_flag_we, a_flag_n, a_flag_z, a_done;
  logic [31:0] a_mul_op1, a_mul_op2, a_wb_data;
  logic [63:0] a_mul_acc;
  logic [3:0]  a_wb_addr;
  logic        b_busy, b_mul_vld, b_mul_sign, b_wb_en, b_flag_we, b_flag_n, b_flag_z, b_done;
  logic [31:0] b_mul_op1, b_mul_op2, b_wb_data;
  logic [63:0] b_mul_acc;
  logic [3:0]  b_wb_addr;

  bit sel = 1'b0;
  int total = 0, passed = 0, failed = 0;

  wire        obs_busy    = sel ? b_busy    : a_busy;
  wire        obs_mul_vld = sel ? b_mul_vld : a_mul_vld;
  wire        obs_sign    = sel ? b_mul_sign : a_mul_sign;
  wire [31:0] obs_op1     = sel ? b_mul_op1 : a_mul_op1;
  wire [31:0] obs_op2     = sel ? b_mul_op2 : a_mul_op2;
  wire [63:0] obs_acc     = sel ? b_mul_acc : a_mul_acc;
  wire        obs_wb_en   = sel ? b_wb_en   : a_wb_en;
  wire [3:0]  obs_addr    = sel ? b_wb_addr : a_wb_addr;
  wire [31:0] obs_data    = sel ? b_wb_data : a_wb_data;
  wire        obs_flag_we = sel ? b_flag_we : a_flag_we;
  wire        obs_n       = sel ? b_flag_n  : a_flag_n;
  wire        obs_z       = sel ? b_flag_z  : a_flag_z;
  wire        obs_done    = sel ? b_done    : a_done;

  mul_sequencer #(.MUL_LATENCY(1), .REG_AW(4)) dut_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_long(i_long), .i_sign(i_sign),
    .i_accum(i_accum), .i_setf(i_setf), .i_rm(i_rm), .i_rs(i_rs), .i_acc_lo(i_acc_lo),
    .i_acc_hi(i_acc_hi), .i_rd_lo(i_rd_lo), .i_rd_hi(i_rd_hi), .i_flush(i_flush),
    .o_busy(a_busy), .o_mul_vld(a_mul_vld), .o_mul_sign(a_mul_sign), .o_mul_op1(a_mul_op1),
    .o_mul_op2(a_mul_op2), .o_mul_acc(a_mul_acc), .i_mul_vld(i_mul_vld),
    .i_mul_result(i_mul_result), .o_wb_en(a_wb_en), .i_wb_gnt(i_wb_gnt),
    .o_wb_addr(a_wb_addr), .o_wb_data(a_wb_data), .o_flag_we(a_flag_we),
    .o_flag_n(a_flag_n), .o_flag_z(a_flag_z), .o_done(a_done)
  );

  mul_sequencer #(.MUL_LATENCY(3), .REG_AW(4)) dut_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_long(i_long), .i_sign(i_sign),
    .i_accum(i_accum), .i_setf(i_setf), .i_rm(i_rm), .i_rs(i_rs), .i_acc_lo(i_acc_lo),
    .i_acc_hi(i_acc_hi), .i_rd_lo(i_rd_lo), .i_rd_hi(i_rd_hi), .i_flush(i_flush),
    .o_busy(b_busy), .o_mul_vld(b_mul_vld), .o_mul_sign(b_mul_sign), .o_mul_op1(b_mul_op1),
    .o_mul_op2(b_mul_op2), .o_mul_acc(b_mul_acc), .i_mul_vld(i_mul_vld),
    .i_mul_result(i_mul_result), .o_wb_en(b_wb_en), .i_wb_gnt(i_wb_gnt),
    .o_wb_addr(b_wb_addr), .o_wb_data(b_wb_data), .o_flag_we(b_flag_we),
    .o_flag_n(b_flag_n), .o_flag_z(b_flag_z), .o_done(b_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d passed=%0d", total, passed);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Randomise the instruction fields while busy; none of it may be taken.
  task automatic scramble();
    i_start  = 1'($urandom);
    i_long   = 1'($urandom);
    i_sign   = 1'($urandom);
    i_accum  = 1'($urandom);
    i_setf   = 1'($urandom);
    i_rm     = $urandom;
    i_rs     = $urandom;
    i_acc_lo = $urandom;
    i_acc_hi = $urandom;
    i_rd_lo  = 4'($urandom);
    i_rd_hi  = 4'($urandom);
  endtask

  function automatic logic [63:0] ref_mul(input bit lng, input bit sgn, input bit acc,
                                          input logic [31:0] rm, input logic [31:0] rs,
                                          input logic [31:0] lo, input logic [31:0] hi);
    longint a, b;
    logic [63:0] addend;
    if (lng && sgn) begin
      a = longint'($signed(rm));
      b = longint'($signed(rs));
    end else begin
      a = longint'({32'd0, rm});
      b = longint'({32'd0, rs});
    end
    addend = !acc ? 64'd0 : (lng ? {hi, lo} : {32'd0, lo});
    return 64'(a * b) + addend;
  endfunction

  task automatic wb_phase(input logic [3:0] addr, input logic [31:0] data, input int gw,
                          input bit fin, input bit setf, input bit n, input bit z);
    for (int g = 0; g < gw; g++) begin
      tick();
      scramble();
      i_mul_vld = 1'($urandom);
      i_mul_result = {$urandom, $urandom};
      i_wb_gnt = 1'b0;
      settle();
      chk("hold_wb_en", 64'(obs_wb_en), 64'd1);
      chk("hold_addr", 64'(obs_addr), 64'(addr));
      chk("hold_data", 64'(obs_data), 64'(data));
      chk("hold_done", 64'(obs_done), 64'd0);
      chk("hold_flag_we", 64'(obs_flag_we), 64'd0);
    end
    tick();
    scramble();
    i_mul_vld = 1'($urandom);
    i_mul_result = {$urandom, $urandom};
    i_wb_gnt = 1'b1;
    settle();
    chk("gnt_wb_en", 64'(obs_wb_en), 64'd1);
    chk("gnt_addr", 64'(obs_addr), 64'(addr));
    chk("gnt_data", 64'(obs_data), 64'(data));
    chk("gnt_done", 64'(obs_done), 64'(fin));
    chk("gnt_flag_we", 64'(obs_flag_we), 64'(fin && setf));
    if (fin && setf) begin
      chk("flag_n", 64'(obs_n), 64'(n));
      chk("flag_z", 64'(obs_z), 64'(z));
    end
  endtask

  task automatic run_op(input bit lng, input bit sgn, input bit acc, input bit setf,
                        input logic [31:0] rm, input logic [31:0] rs,
                        input logic [31:0] alo, input logic [31:0] ahi,
                        input logic [3:0] rlo, input logic [3:0] rhi,
                        input int gw_lo, input int gw_hi, input int vwait);
    logic [63:0] exp_res, exp_acc;
    int lat;
    bit n, z;
    lat = sel ? 3 : 1;
    exp_res = ref_mul(lng, sgn, acc, rm, rs, alo, ahi);
    exp_acc = !acc ? 64'd0 : (lng ? {ahi, alo} : {32'd0, alo});
    n = lng ? exp_res[63] : exp_res[31];
    z = lng ? (exp_res == 64'd0) : (exp_res[31:0] == 32'd0);
    tick();
    i_start = 1'b1; i_long = lng; i_sign = sgn; i_accum = acc; i_setf = setf;
    i_rm = rm; i_rs = rs; i_acc_lo = alo; i_acc_hi = ahi; i_rd_lo = rlo; i_rd_hi = rhi;
    i_mul_vld = 1'b0; i_wb_gnt = 1'b0; i_flush = 1'b0;
    settle();
    chk("start_busy", 64'(obs_busy), 64'd0);
    tick();
    scramble();
    i_mul_vld = 1'($urandom);
    i_mul_result = ~exp_res;
    settle();
    chk("issue_vld", 64'(obs_mul_vld), 64'd1);
    chk("issue_busy", 64'(obs_busy), 64'd1);
    chk("issue_op1", 64'(obs_op1), 64'(rm));
    chk("issue_op2", 64'(obs_op2), 64'(rs));
    chk("issue_acc", obs_acc, exp_acc);
    chk("issue_sign", 64'(obs_sign), 64'(lng && sgn));
    for (int k = 1; k < lat; k++) begin
      tick();
      scramble();
      i_mul_vld = 1'b1;
      i_mul_result = ~exp_res;
      settle();
      chk("early_mul_vld", 64'(obs_mul_vld), 64'd0);
      chk("early_wb_en", 64'(obs_wb_en), 64'd0);
    end
    for (int j = 0; j < vwait; j++) begin
      tick();
      scramble();
      i_mul_vld = 1'b0;
      i_mul_result = ~exp_res;
      settle();
      chk("wait_wb_en", 64'(obs_wb_en), 64'd0);
    end
    tick();
    scramble();
    i_mul_vld = 1'b1;
    i_mul_result = exp_res;
    settle();
    chk("capture_wb_en", 64'(obs_wb_en), 64'd0);
    chk("capture_busy", 64'(obs_busy), 64'd1);
    wb_phase(rlo, exp_res[31:0], gw_lo, !lng, setf, n, z);
    if (lng)
      wb_phase(rhi, exp_res[63:32], gw_hi, 1'b1, setf, n, z);
    tick();
    i_start = 1'b0; i_wb_gnt = 1'b0; i_mul_vld = 1'b0;
    settle();
    chk("end_busy", 64'(obs_busy), 64'd0);
    chk("end_wb_en", 64'(obs_wb_en), 64'd0);
  endtask

  task automatic do_reset();
    i_start = 1'b0; i_long = 1'b0; i_sign = 1'b0; i_accum = 1'b0; i_setf = 1'b0;
    i_rm = 32'd0; i_rs = 32'd0; i_acc_lo = 32'd0; i_acc_hi = 32'd0;
    i_rd_lo = 4'd0; i_rd_hi = 4'd0; i_flush = 1'b0; i_mul_vld = 1'b0;
    i_mul_result = 64'd0; i_wb_gnt = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic random_ops(input int count);
    for (int i = 0; i < count; i++) begin
      logic [31:0] rm;
      rm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rm, $urandom,
             $urandom, $urandom, 4'($urandom), 4'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    do_reset();
    sel = 1'b0;
    chk("rst_busy", 64'(obs_busy), 64'd0);
    chk("rst_mul_vld", 64'(obs_mul_vld), 64'd0);
    chk("rst_wb_en", 64'(obs_wb_en), 64'd0);
    chk("rst_wb_addr", 64'(obs_addr), 64'd0);
    chk("rst_wb_data", 64'(obs_data), 64'd0);
    chk("rst_op1", 64'(obs_op1), 64'd0);
    chk("rst_acc", obs_acc, 64'd0);
    chk("rst_flag_z", 64'(obs_z), 64'd0);
    chk("rst_done", 64'(obs_done), 64'd0);

    // MUL r3 = 7*6 with S; SMULL; UMLAL; MULS with slow grant; RdLo == RdHi
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 32'd6, 32'd0, 32'd0, 4'd3, 4'd0, 0, 0, 0);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 4'd4, 4'd5, 0, 0, 0);
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd6, 4'd7, 0, 0, 0);
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd5, 32'd0, 32'd0, 4'd2, 4'd0, 3, 0, 0);
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0, 4'd7, 4'd7, 1, 2, 1);
    random_ops(20);

    // Flush while waiting: late result and grants must be ignored
    tick();
    i_start = 1'b1; i_long = 1'b1; i_sign = 1'b0; i_accum = 1'b0; i_setf = 1'b1;
    i_rm = 32'd3; i_rs = 32'd5; i_rd_lo = 4'd1; i_rd_hi = 4'd2;
    settle();
    tick();
    i_start = 1'b0;
    settle();
    tick();
    i_flush = 1'b1;
    settle();
    chk("flush_wait_wb_en", 64'(obs_wb_en), 64'd0);
    tick();
    i_flush = 1'b0; i_mul_vld = 1'b1; i_mul_result = 64'd15; i_wb_gnt = 1'b1;
    settle();
    chk("flush_idle_busy", 64'(obs_busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("flush_late_wb_en", 64'(obs_wb_en), 64'd0);
      chk("flush_late_done", 64'(obs_done), 64'd0);
      chk("flush_late_flag_we", 64'(obs_flag_we), 64'd0);
    end
    i_mul_vld = 1'b0; i_wb_gnt = 1'b0;

    // Flush in the same cycle as the grant
    tick();
    i_start = 1'b1; i_long = 1'b0; i_setf = 1'b1; i_rm = 32'd9; i_rs = 32'd9; i_rd_lo = 4'd6;
    settle();
    tick();
    i_start = 1'b0;
    settle();
    tick();
    i_mul_vld = 1'b1; i_mul_result = 64'd81;
    settle();
    tick();
    i_mul_vld = 1'b0; i_wb_gnt = 1'b1; i_flush = 1'b1;
    settle();
    chk("flushgnt_wb_en", 64'(obs_wb_en), 64'd0);
    chk("flushgnt_done", 64'(obs_done), 64'd0);
    chk("flushgnt_flag_we", 64'(obs_flag_we), 64'd0);
    tick();
    i_flush = 1'b0; i_wb_gnt = 1'b0;
    settle();
    chk("flushgnt_busy", 64'(obs_busy), 64'd0);

    // Asynchronous reset while holding the RdHi write
    tick();
    i_start = 1'b1; i_long = 1'b1; i_setf = 1'b1; i_rm = 32'h10000; i_rs = 32'h10000;
    i_rd_lo = 4'd8; i_rd_hi = 4'd9;
    settle();
    tick();
    i_start = 1'b0;
    settle();
    tick();
    i_mul_vld = 1'b1; i_mul_result = 64'h1_0000_0000;
    settle();
    tick();
    i_mul_vld = 1'b0; i_wb_gnt = 1'b1;
    settle();
    chk("rstwb_lo_addr", 64'(obs_addr), 64'd8);
    tick();
    i_wb_gnt = 1'b0;
    settle();
    chk("rstwb_hi_addr", 64'(obs_addr), 64'd9);
    chk("rstwb_hi_data", 64'(obs_data), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(obs_busy), 64'd0);
    chk("async_rst_wb_en", 64'(obs_wb_en), 64'd0);
    chk("async_rst_op1", 64'(obs_op1), 64'd0);
    i_wb_gnt = 1'b1;
    #1;
    chk("async_rst_done", 64'(obs_done), 64'd0);
    tick();
    rst = 1'b0; i_wb_gnt = 1'b0;
    settle();
    chk("post_rst_busy", 64'(obs_busy), 64'd0);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 4'd1, 4'd0, 0, 0, 0);

    // Latency-3 instance: early valid results must not be captured
    do_reset();
    sel = 1'b1;
    chk("lat3_rst_busy", 64'(obs_busy), 64'd0);
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 32'd123, 32'd456, 32'd10, 32'd0, 4'd5, 4'd0, 0, 0, 0);
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h80000000, 32'd2, 32'd5, 32'hFFFFFFFF, 4'd1, 4'd2, 1, 0, 2);
    random_ops(8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
